// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundles the fetch port, data port, memory command/response bus
//             and status outputs of the shared-memory arbiter.
//             slave  = arbiter side, master = requesters/memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
  // fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  // load/store port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ubhw;
  logic        d_ack;
  logic [31:0] d_rdata;
  // memory command / response
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ubhw;
  logic [31:0] m_rdata;
  // status
  logic        busy;
  logic        grant_d;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_ubhw, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_ubhw, busy, grant_d
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_ubhw, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_ubhw, busy, grant_d
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one fixed-latency single-port memory between the fetch
//             port and the load/store port. One transaction in flight, data
//             port has priority, a starvation counter forces a fetch win
//             after STARVE_MAX consecutive contested losses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int LAT        = 2,  // cycles from m_en to m_rdata valid, >= 1
  parameter int STARVE_MAX = 4   // contested fetch losses before forced win, >= 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int c_wait_w   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int c_starve_w = $clog2(STARVE_MAX + 1);
  localparam logic [2:0] c_ubhw_word = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q,   state_d;
  logic [c_wait_w-1:0]   wait_q,    wait_d;
  logic [c_starve_w-1:0] starve_q,  starve_d;
  logic                  m_en_q,    m_en_d;
  logic                  m_we_q,    m_we_d;
  logic [31:0]           m_addr_q,  m_addr_d;
  logic [31:0]           m_wdata_q, m_wdata_d;
  logic [2:0]            m_ubhw_q,  m_ubhw_d;
  logic                  i_ack_q,   i_ack_d;
  logic                  d_ack_q,   d_ack_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  grant_d_q, grant_d_d;
  logic                  busy_q,    busy_d;

  logic w_contested;
  logic w_data_wins;

  // Winner selection: data first, unless fetch has already lost STARVE_MAX contests
  always_comb begin
    w_contested = bus.i_req && bus.d_req;
    w_data_wins = bus.d_req &&
                  (!bus.i_req || (starve_q != c_starve_w'(STARVE_MAX)));
  end

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    m_en_d    = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_ubhw_d  = m_ubhw_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d_d = grant_d_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // Request fields are captured here only; the command stays frozen
          state_d = S_ISSUE;
          m_en_d  = 1'b1;
          if (w_data_wins) begin
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_ubhw_d  = bus.d_ubhw;
            grant_d_d = 1'b1;
            if (w_contested && (starve_q != c_starve_w'(STARVE_MAX))) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = 32'd0;
            m_ubhw_d  = c_ubhw_word;
            grant_d_d = 1'b0;
            starve_d  = '0;
          end
        end
      end

      S_ISSUE: begin
        // m_en is high during this state; count the remaining latency
        wait_d  = c_wait_w'(LAT - 1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          // m_rdata is valid this cycle; stores leave the read registers alone
          if (!m_we_q) begin
            if (grant_d_q) begin
              d_rdata_d = bus.m_rdata;
            end else begin
              i_rdata_d = bus.m_rdata;
            end
          end
          d_ack_d = grant_d_q;
          i_ack_d = !grant_d_q;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state and outputs registered; reset discards any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      starve_q  <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      m_ubhw_q  <= 3'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      grant_d_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_ubhw_q  <= m_ubhw_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      grant_d_q <= grant_d_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_ubhw  = m_ubhw_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.grant_d = grant_d_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data/instruction memory between the IF fetch port and the MEM-stage load/store port of the 5-stage RV32 core.
- Accepts at most one outstanding transaction at a time.
- Sequences it against a fixed-latency memory and returns a one-cycle ack to the winning requester.
- Data port has priority; an anti-starvation counter guarantees fetch progress. Pipeline stall logic uses `i_ack`, `d_ack` and `busy`.

Parameters:
- `LAT`, 2, memory read latency in cycles from the `m_en` cycle to `m_rdata` valid. Must be ≥1.
- `STARVE_MAX`, 4, consecutive contested arbitrations the fetch port may lose before it is forced to win. Must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `i_req`  in  1  fetch request, level, held until `i_ack`
- `i_addr`  in  32  fetch byte address
- `i_ack`  out  1  one-cycle fetch completion pulse
- `i_rdata`  out  32  fetched word, valid while `i_ack`=1, held afterwards
- `d_req`  in  1  data request, level, held until `d_ack`
- `d_we`  in  1  1=store, 0=load
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_ubhw`  in  3  funct3 width/sign code (`u_b_h_w`)
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  32  load data, valid while `d_ack`=1
- `m_en`  out  1  memory command strobe, one cycle per transaction
- `m_we`  out  1  memory write enable, qualified by `m_en`
- `m_addr`  out  32  memory address
- `m_wdata`  out  32  memory write data
- `m_ubhw`  out  3  memory width code
- `m_rdata`  in  32  memory read data, valid exactly `LAT` cycles after the `m_en` cycle
- `busy`  out  1  1 when state ≠ IDLE
- `grant_d`  out  1  owner of the current/last transaction (1=data, 0=fetch)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; `m_en`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `m_ubhw`=0; `i_ack`=0, `d_ack`=0; `i_rdata`=0, `d_rdata`=0; `grant_d`=0; starve counter=0; wait counter=0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch its addr/we/wdata/ubhw into the command registers (fetch: `we`=0, `ubhw`=3'b010), set `grant_d`, and go to ISSUE.
  - Request fields are sampled only at this edge; later changes are ignored.
- Arbitration:
  - Only one request high → it wins.
  - Both high → data wins unless starve counter == `STARVE_MAX`, in which case fetch wins.
  - Starve counter increments on each contested data win (saturating at `STARVE_MAX`) and clears whenever fetch wins.
- ISSUE: `m_en`=1 for exactly this cycle with the latched command. Wait counter loads `LAT`-1. Go to WAIT.
- WAIT:
  - `m_en`=0; the counter decrements each cycle.
  - In the cycle the counter is 0 (cycle ISSUE+`LAT`), `m_rdata` is captured into the owner's rdata register. Stores capture nothing.
  - Then go to RESP.
- RESP: the owner's ack=1 for one cycle; the other ack stays 0. Go to IDLE.
- Latency: request high in IDLE cycle t → `m_en` at t+1 → ack at t+2+`LAT`. Minimum IDLE-to-IDLE period is `LAT`+3 cycles.
- Requester protocol: the requester drops or changes `req` on the edge after seeing its ack. A `req` sampled in the IDLE cycle following RESP is a new request.
- Re-arbitration: a requester that loses keeps `req` high and is re-arbitrated in the next IDLE.
- Rdata hold: `i_rdata` and `d_rdata` hold their values until the next read for that port. A store ack leaves `d_rdata` unchanged.
- Reset mid-transaction: `rst` in any state forces IDLE on the next edge. The pending response is discarded: no ack is issued and `m_rdata` is ignored. Starve counter clears.
- `rst` and `req` together: reset wins; `req` is first sampled in the IDLE cycle after `rst` deasserts.

Test Plan:
- Lone fetch, `LAT`=2: `i_req`=1, `i_addr`=0x40 at cycle 0; memory drives 0x00A00093 at cycle 3 → `m_en`=1, `m_we`=0, `m_addr`=0x40 at cycle 1; `i_ack`=1 with `i_rdata`=0x00A00093 at cycle 4; `d_ack`=0 throughout.
- Lone store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_ubhw`=3'b010 at cycle 0 → cycle 1 shows `m_en`=1, `m_we`=1 with identical fields; `d_ack` at cycle 4; `d_rdata` unchanged from its previous value.
- Contention: both `req` high at cycle 0 → `grant_d`=1; `d_ack` at cycle 4; fetch wins IDLE at cycle 5, `m_en` at cycle 6, `i_ack` at cycle 9.
- Starvation, `STARVE_MAX`=4: `i_req` held high, `d_req` re-asserted every IDLE → exactly 4 data acks, then the 5th grant goes to fetch; the following contested grant is data again.
- Reset mid-op: `rst`=1 for one cycle during WAIT of a load → next cycle `busy`=0; no `d_ack` ever pulses for that load; a re-issued load completes with normal `LAT`+2 latency.
- `LAT`=1 build: lone load at cycle 0 → `m_en` at cycle 1, data captured at cycle 2, `d_ack` at cycle 3.
